param_fifo: RTL and testbench
=============================

PARAM_FIFO -- requirements
Module: param_fifo

Interface
REQ-001 Parameter WIDTH, default 32: data word width in bits, range 1 or greater.
REQ-002 Parameter DEPTH, default 8: number of entries, a power of 2 and 2 or greater.
REQ-003 Parameter AF_LEVEL, default DEPTH-2: ALMOST_FULL asserts when Count is AF_LEVEL or greater.
REQ-004 Parameter AE_LEVEL, default 2: ALMOST_EMPTY asserts when Count is AE_LEVEL or less.
REQ-005 Parameter FWFT, default 0: 0 selects registered-read mode; 1 selects first-word-fall-through mode.
REQ-006 Clk  in  1  single clock; all state changes on its rising edge.
REQ-007 Rst  in  1  synchronous, active-high reset.
REQ-008 EN  in  1  clock enable; when low, no state changes except reset.
REQ-009 WR  in  1  write request.
REQ-010 RD  in  1  read request (pop).
REQ-011 dataIn  in  WIDTH  write data.
REQ-012 dataOut  out  WIDTH  read data.
REQ-013 EMPTY, FULL, ALMOST_EMPTY, ALMOST_FULL  out  1 each  status flags derived from Count.
REQ-014 Count  out  clog2(DEPTH)+1  current occupancy, 0 to DEPTH inclusive.
REQ-015 OVERFLOW, UNDERFLOW  out  1 each  sticky error flags.

Function
REQ-016 Pointers SHALL be clog2(DEPTH) bits wide and wrap naturally from DEPTH-1 to 0; no compare-and-clear of pointers.
REQ-017 Count SHALL be a dedicated register, never derived from pointer difference; EMPTY SHALL equal (Count==0) and FULL SHALL equal (Count==DEPTH).
REQ-018 Accepted write: WR=1 and (FULL=0, or RD accepted in the same cycle); writes dataIn to mem[wptr] and increments wptr.
REQ-019 Accepted read: RD=1 and EMPTY=0; increments rptr.
REQ-020 Count update per cycle: +1 on write only, -1 on read only, unchanged on both or neither.
REQ-021 Simultaneous RD and WR when EMPTY: the write is accepted, the read is rejected, and UNDERFLOW is set.
REQ-022 Simultaneous RD and WR when FULL: both are accepted and Count stays at DEPTH.
REQ-023 WR=1 while FULL=1 and RD=0: the write is dropped and OVERFLOW is set.
REQ-024 RD=1 while EMPTY=1: no pointer change and UNDERFLOW is set.
REQ-025 OVERFLOW and UNDERFLOW SHALL hold once set until Rst.
REQ-026 FWFT=0: on an accepted read, dataOut SHALL take mem[rptr] at the same edge (1-cycle latency); otherwise dataOut holds its value.
REQ-027 FWFT=1: dataOut SHALL present the head entry whenever EMPTY=0; RD acknowledges and pops it; data written into an empty FIFO SHALL appear on dataOut one cycle after the write edge.
REQ-028 FWFT=1 with EMPTY=1: dataOut holds its last value.
REQ-029 EN=0: pointers, Count, memory, dataOut and error flags SHALL be frozen, and RD/WR are ignored (they set no error flags).
REQ-030 Status flags SHALL be combinational from Count, so they are valid in the same cycle Count changes.

Reset
REQ-031 Rst=1 at a clock edge SHALL take priority over EN, RD and WR.
REQ-032 Reset SHALL clear rptr, wptr, Count, dataOut, OVERFLOW and UNDERFLOW to 0; memory contents are not cleared.
REQ-033 After reset: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=0 (for AF_LEVEL greater than 0).
REQ-034 Reset mid-operation SHALL discard all stored entries; any RD or WR in the reset cycle is ignored.

Structure
REQ-035 Package param_fifo_pkg SHALL hold the default WIDTH/DEPTH constants and a count-width function (clog2(DEPTH)+1).
REQ-036 Storage SHALL be the sub-module param_fifo_mem: a one-write, one-read-port array with WIDTH and DEPTH parameters.
REQ-037 Elaboration SHALL fail for non-power-of-2 DEPTH or for AF_LEVEL greater than DEPTH.

Verification (WIDTH=32, DEPTH=8, FWFT=0 unless stated)
REQ-038 Reset, then 8 writes of 0x1..0x8 -> FULL=1 after the 8th edge, Count=8, ALMOST_FULL=1 from Count=6, OVERFLOW=0.
REQ-039 9th write 0xDEAD while full -> dropped, OVERFLOW=1; 8 reads -> dataOut 0x1..0x8 in order, each 1 cycle after RD.
REQ-040 Write/read streaming 20 words (0x10..0x23) with RD and WR high together after the first write -> Count stays at 1, and pointer wrap produces no data loss or reorder.
REQ-041 FULL with RD=WR=1 -> Count=8 held, dataOut=oldest word, new word stored; EMPTY with RD=WR=1 -> Count=1, UNDERFLOW=1.
REQ-042 FWFT=1: write 0xA5 into empty -> dataOut=0xA5 one cycle later with RD=0; RD pops it -> EMPTY=1.
REQ-043 Load 5 words, drop EN for 3 cycles toggling RD/WR -> nothing changes; then Rst with EN=0 -> Count=0, EMPTY=1, flags cleared.

Source files
------------

// File: rtl/param_fifo_pkg.sv
// Shared constants and sizing helpers for the parameterised synchronous FIFO.
package param_fifo_pkg;

   localparam int unsigned DEFAULT_WIDTH = 32;
   localparam int unsigned DEFAULT_DEPTH = 8;

   // Occupancy needs one extra bit so that DEPTH itself is representable.
   function automatic int unsigned count_width(input int unsigned depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/param_fifo_mem.sv
// Storage array for param_fifo: one synchronous write port, one asynchronous read port.
module param_fifo_mem #(
   parameter int unsigned WIDTH = 32,
   parameter int unsigned DEPTH = 8
) (
   input  logic                       clk,
   input  logic                       we,
   input  logic [$clog2(DEPTH)-1:0]   waddr,
   input  logic [WIDTH-1:0]           wdata,
   input  logic [$clog2(DEPTH)-1:0]   raddr,
   output logic [WIDTH-1:0]           rdata
);

   logic [WIDTH-1:0] mem [DEPTH];

   always_ff @(posedge clk) begin
      if (we) begin
         mem[waddr] <= wdata;
      end
   end

   assign rdata = mem[raddr];

endmodule

// File: rtl/param_fifo.sv
// Synchronous FIFO with dedicated occupancy counter, sticky error flags and
// selectable registered-read or first-word-fall-through output.
module param_fifo
   import param_fifo_pkg::*;
#(
   parameter int unsigned WIDTH    = DEFAULT_WIDTH,
   parameter int unsigned DEPTH    = DEFAULT_DEPTH,
   parameter int unsigned AF_LEVEL = DEPTH - 2,
   parameter int unsigned AE_LEVEL = 2,
   parameter int unsigned FWFT     = 0
) (
   input  logic                          Clk,
   input  logic                          Rst,
   input  logic                          EN,
   input  logic                          WR,
   input  logic                          RD,
   input  logic [WIDTH-1:0]              dataIn,
   output logic [WIDTH-1:0]              dataOut,
   output logic                          EMPTY,
   output logic                          FULL,
   output logic                          ALMOST_EMPTY,
   output logic                          ALMOST_FULL,
   output logic [count_width(DEPTH)-1:0] Count,
   output logic                          OVERFLOW,
   output logic                          UNDERFLOW
);

   localparam int unsigned AW = $clog2(DEPTH);
   localparam int unsigned CW = count_width(DEPTH);

   // Reject illegal parameterisations at elaboration time.
   if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
      $error("param_fifo: DEPTH must be a power of 2 and at least 2");
   end
   if (AF_LEVEL > DEPTH) begin : g_bad_af
      $error("param_fifo: AF_LEVEL must not exceed DEPTH");
   end
   if (WIDTH < 1) begin : g_bad_width
      $error("param_fifo: WIDTH must be at least 1");
   end

   logic [AW-1:0]    rptr;
   logic [AW-1:0]    wptr;
   logic [AW-1:0]    rptr_next;
   logic [AW-1:0]    raddr;
   logic [CW-1:0]    count_next;
   logic [WIDTH-1:0] rdata;
   logic             rd_ok;
   logic             wr_ok;
   logic             head_is_new;

   assign EMPTY        = (Count == '0);
   assign FULL         = (Count == CW'(DEPTH));
   assign ALMOST_FULL  = (32'(Count) >= AF_LEVEL);
   assign ALMOST_EMPTY = (32'(Count) <= AE_LEVEL);

   // Acceptance, next pointers and next occupancy for the current request.
   always_comb begin
      rd_ok       = RD && !EMPTY;
      wr_ok       = WR && (!FULL || rd_ok);
      rptr_next   = rd_ok ? rptr + AW'(1) : rptr;
      count_next  = Count;
      if (wr_ok && !rd_ok) begin
         count_next = Count + CW'(1);
      end else if (rd_ok && !wr_ok) begin
         count_next = Count - CW'(1);
      end
      // The word being written becomes the head when nothing older remains.
      head_is_new = wr_ok && (Count == CW'(rd_ok));
   end

   // FWFT looks ahead to the post-pop head; registered mode reads the current head.
   assign raddr = (FWFT != 0) ? rptr_next : rptr;

   param_fifo_mem #(
      .WIDTH (WIDTH),
      .DEPTH (DEPTH)
   ) u_mem (
      .clk   (Clk),
      .we    (EN && !Rst && wr_ok),
      .waddr (wptr),
      .wdata (dataIn),
      .raddr (raddr),
      .rdata (rdata)
   );

   always_ff @(posedge Clk) begin
      if (Rst) begin
         rptr      <= '0;
         wptr      <= '0;
         Count     <= '0;
         dataOut   <= '0;
         OVERFLOW  <= 1'b0;
         UNDERFLOW <= 1'b0;
      end else if (EN) begin
         if (wr_ok) begin
            wptr <= wptr + AW'(1);
         end
         rptr  <= rptr_next;
         Count <= count_next;
         if (WR && !wr_ok) begin
            OVERFLOW <= 1'b1;
         end
         if (RD && !rd_ok) begin
            UNDERFLOW <= 1'b1;
         end
         if (FWFT == 0) begin
            if (rd_ok) begin
               dataOut <= rdata;
            end
         end else if (count_next != '0) begin
            dataOut <= head_is_new ? dataIn : rdata;
         end
      end
   end

endmodule

// File: tb/tb_param_fifo.sv
// Randomised and directed bench for param_fifo in both read modes against a queue model.
module tb_param_fifo;

   localparam int unsigned WIDTH    = 32;
   localparam int unsigned DEPTH    = 8;
   localparam int unsigned AF_LEVEL = 6;
   localparam int unsigned AE_LEVEL = 2;

   logic              clk = 1'b0;
   logic              rst;
   logic              en;
   logic              wr;
   logic              rd;
   logic [WIDTH-1:0]  din;

   logic [WIDTH-1:0]  dout0, dout1;
   logic              empty0, full0, ae0, af0, ovf0, unf0;
   logic              empty1, full1, ae1, af1, ovf1, unf1;
   logic [3:0]        cnt0, cnt1;

   int unsigned       n_checks = 0;
   int unsigned       n_pass   = 0;

   logic [WIDTH-1:0]  q[$];
   logic [WIDTH-1:0]  m_d0 = '0;
   logic [WIDTH-1:0]  m_d1 = '0;
   logic              m_ovf = 1'b0;
   logic              m_unf = 1'b0;

   always #5 clk = ~clk;

   param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(0)) u_dut0 (
      .Clk(clk), .Rst(rst), .EN(en), .WR(wr), .RD(rd), .dataIn(din), .dataOut(dout0),
      .EMPTY(empty0), .FULL(full0), .ALMOST_EMPTY(ae0), .ALMOST_FULL(af0),
      .Count(cnt0), .OVERFLOW(ovf0), .UNDERFLOW(unf0)
   );

   param_fifo #(.WIDTH(WIDTH), .DEPTH(DEPTH), .AF_LEVEL(AF_LEVEL), .AE_LEVEL(AE_LEVEL), .FWFT(1)) u_dut1 (
      .Clk(clk), .Rst(rst), .EN(en), .WR(wr), .RD(rd), .dataIn(din), .dataOut(dout1),
      .EMPTY(empty1), .FULL(full1), .ALMOST_EMPTY(ae1), .ALMOST_FULL(af1),
      .Count(cnt1), .OVERFLOW(ovf1), .UNDERFLOW(unf1)
   );

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) begin
         n_pass++;
      end else begin
         $display("FAIL %s @%0t: got 0x%0h expected 0x%0h", tag, $time, got, exp);
      end
   endtask

   // Reference behaviour: a bounded queue with sticky error flags.
   task automatic model_update(input logic r, input logic e, input logic w, input logic rr,
                               input logic [WIDTH-1:0] d);
      bit rd_acc, wr_acc;
      if (r) begin
         q.delete();
         m_d0  = '0;
         m_d1  = '0;
         m_ovf = 1'b0;
         m_unf = 1'b0;
      end else if (e) begin
         rd_acc = rr && (q.size() != 0);
         wr_acc = w && ((q.size() < DEPTH) || rd_acc);
         if (rr && !rd_acc) m_unf = 1'b1;
         if (w && !wr_acc)  m_ovf = 1'b1;
         if (rd_acc) m_d0 = q.pop_front();
         if (wr_acc) q.push_back(d);
         if (q.size() != 0) m_d1 = q[0];
      end
   endtask

   task automatic compare_all();
      int n;
      n = q.size();
      check("count0", 64'(cnt0),   64'(n));
      check("count1", 64'(cnt1),   64'(n));
      check("empty0", 64'(empty0), 64'(n == 0));
      check("empty1", 64'(empty1), 64'(n == 0));
      check("full0",  64'(full0),  64'(n == DEPTH));
      check("full1",  64'(full1),  64'(n == DEPTH));
      check("ae0",    64'(ae0),    64'(n <= AE_LEVEL));
      check("ae1",    64'(ae1),    64'(n <= AE_LEVEL));
      check("af0",    64'(af0),    64'(n >= AF_LEVEL));
      check("af1",    64'(af1),    64'(n >= AF_LEVEL));
      check("ovf0",   64'(ovf0),   64'(m_ovf));
      check("ovf1",   64'(ovf1),   64'(m_ovf));
      check("unf0",   64'(unf0),   64'(m_unf));
      check("unf1",   64'(unf1),   64'(m_unf));
      check("dout0",  64'(dout0),  64'(m_d0));
      check("dout1",  64'(dout1),  64'(m_d1));
   endtask

   // One clock: drive, let the edge pass, advance the model, compare away from the edge.
   task automatic step(input logic r, input logic e, input logic w, input logic rr,
                       input logic [WIDTH-1:0] d);
      rst = r; en = e; wr = w; rd = rr; din = d;
      @(posedge clk);
      model_update(r, e, w, rr, d);
      #1;
      compare_all();
   endtask

   initial begin
      logic [WIDTH-1:0] hold0;
      int               p_wr, p_rd;

      // Reset state and sequential fill to full.
      step(1, 1, 0, 0, '0);
      check("rst_empty", 64'(empty0), 64'(1));
      check("rst_ae",    64'(ae0),    64'(1));
      check("rst_af",    64'(af0),    64'(0));
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 1, 0, WIDTH'(i + 1));
         check("fill_af", 64'(af0), 64'((i + 1) >= 6));
      end
      check("fill_full",  64'(full0), 64'(1));
      check("fill_count", 64'(cnt0),  64'(8));
      check("fill_ovf",   64'(ovf0),  64'(0));

      // Write while full is dropped; then drain in order.
      step(0, 1, 1, 0, 32'hDEAD);
      check("ovf_set", 64'(ovf0), 64'(1));
      check("ovf_cnt", 64'(cnt0), 64'(8));
      for (int i = 0; i < 8; i++) begin
         step(0, 1, 0, 1, '0);
         check("drain_data", 64'(dout0), 64'(i + 1));
      end
      check("drain_empty", 64'(empty0), 64'(1));

      // Streaming with simultaneous read and write across pointer wrap.
      step(1, 1, 0, 0, '0);
      step(0, 1, 1, 0, 32'h10);
      for (int i = 1; i < 20; i++) begin
         step(0, 1, 1, 1, WIDTH'(32'h10 + i));
         check("stream_cnt",  64'(cnt0),  64'(1));
         check("stream_data", 64'(dout0), 64'(32'h10 + i - 1));
      end

      // Simultaneous read/write when full, then when empty.
      step(1, 1, 0, 0, '0);
      for (int i = 0; i < 8; i++) step(0, 1, 1, 0, WIDTH'(32'h100 + i));
      step(0, 1, 1, 1, 32'h1FF);
      check("full_rw_cnt",  64'(cnt0),  64'(8));
      check("full_rw_data", 64'(dout0), 64'(32'h100));
      check("full_rw_ovf",  64'(ovf0),  64'(0));
      for (int i = 0; i < 8; i++) step(0, 1, 0, 1, '0);
      check("full_rw_last", 64'(dout0), 64'(32'h1FF));
      step(0, 1, 1, 1, 32'h77);
      check("empty_rw_cnt", 64'(cnt0), 64'(1));
      check("empty_rw_unf", 64'(unf0), 64'(1));

      // First-word-fall-through presentation and pop.
      step(1, 1, 0, 0, '0);
      step(0, 1, 1, 0, 32'hA5);
      check("fwft_data", 64'(dout1), 64'(32'hA5));
      step(0, 1, 0, 0, '0);
      check("fwft_hold", 64'(dout1), 64'(32'hA5));
      step(0, 1, 0, 1, '0);
      check("fwft_empty", 64'(empty1), 64'(1));

      // Clock enable freeze, then reset while disabled.
      step(1, 1, 0, 0, '0);
      step(0, 1, 0, 1, '0);
      for (int i = 0; i < 5; i++) step(0, 1, 1, 0, WIDTH'(32'h50 + i));
      hold0 = dout1;
      for (int i = 0; i < 3; i++) begin
         step(0, 0, (i % 2) == 0, (i % 2) == 1, 32'hBAD);
         check("en_cnt",  64'(cnt0),  64'(5));
         check("en_head", 64'(dout1), 64'(hold0));
      end
      step(1, 0, 1, 1, 32'hBAD);
      check("rst_en_cnt",   64'(cnt0),   64'(0));
      check("rst_en_empty", 64'(empty0), 64'(1));
      check("rst_en_unf",   64'(unf0),   64'(0));

      // Randomised traffic with biased read/write mixes to visit full and empty.
      for (int ph = 0; ph < 4; ph++) begin
         p_wr = (ph == 0) ? 80 : (ph == 1) ? 20 : 50;
         p_rd = (ph == 0) ? 20 : (ph == 1) ? 80 : 50;
         for (int i = 0; i < 200; i++) begin
            step(($urandom % 100) == 0,
                 ($urandom % 8) != 0,
                 ($urandom % 100) < p_wr,
                 ($urandom % 100) < p_rd,
                 WIDTH'($urandom));
         end
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
